// File: rtl/pipe_trace_buffer.sv
// ---------------------------------------------------------------------------
// pipe_trace_buffer
//
// Retirement-trace capture buffer fed by the writeback pipeline register.
// Retired instructions are recorded into a circular buffer. A PC-match or
// forced trigger starts a fixed post-trigger window, after which capture
// freezes and the captured window is dumped oldest-first over a valid/ready
// stream.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), synchronous active-low reset
//   i_arm                 pulse: start capture (only honoured in IDLE)
//   i_trig_pc_en/i_trig_pc  PC-match trigger enable and target PC
//   i_force_trig          unconditional trigger
//   i_valid, i_pc, i_instr, i_rd, i_reg_write_en, i_rd_data, i_cycle
//                         retiring-instruction bundle from writeback
//   o_state               0 IDLE, 1 ARMED, 2 POST, 3 DUMP (FSM state)
//   o_count               valid entries held, saturates at DEPTH
//   o_triggered           trigger seen, held until the dump completes
//   o_rd_valid/i_rd_ready/o_rd_last  readout stream handshake
//   o_rd_pc, o_rd_instr, o_rd_data, o_rd_cycle, o_rd_rd, o_rd_we
//                         readout entry fields
//
// Readout handshake: a beat transfers on a rising edge where o_rd_valid and
// i_rd_ready are both 1. o_rd_valid never drops and no o_rd_* field changes
// while a beat is offered and not yet accepted. The following entry is
// loaded on the transfer edge, so a consumer holding i_rd_ready high gets
// one beat per cycle.
// ---------------------------------------------------------------------------
module pipe_trace_buffer #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int POST_CNT = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_arm,
  input  logic              i_trig_pc_en,
  input  logic [31:0]       i_trig_pc,
  input  logic              i_force_trig,
  input  logic              i_valid,
  input  logic [31:0]       i_pc,
  input  logic [31:0]       i_instr,
  input  logic [4:0]        i_rd,
  input  logic              i_reg_write_en,
  input  logic [31:0]       i_rd_data,
  input  logic [31:0]       i_cycle,
  output logic [1:0]        o_state,
  output logic [ADDR_W:0]   o_count,
  output logic              o_triggered,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic              o_rd_last,
  output logic [31:0]       o_rd_pc,
  output logic [31:0]       o_rd_instr,
  output logic [31:0]       o_rd_data,
  output logic [31:0]       o_rd_cycle,
  output logic [4:0]        o_rd_rd,
  output logic              o_rd_we
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DUMP  = 2'd3
  } state_t;

  localparam int CNT_W   = ADDR_W + 1;
  localparam int ENTRY_W = 32 + 32 + 5 + 1 + 32 + 32;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] POST_C  = CNT_W'(POST_CNT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

  // Entry layout: {pc, instr, rd, reg_write_en, rd_data, cycle}
  logic [ENTRY_W-1:0] mem [DEPTH];

  state_t             state_q;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   post_left_q;
  logic               triggered_q;
  logic               rd_valid_q;
  logic               rd_last_q;
  logic [ENTRY_W-1:0] rd_entry_q;

  logic               capture;
  logic               wr_en;
  logic               pc_hit;
  logic               trig;
  logic [ADDR_W-1:0]  oldest_ptr;
  logic [ENTRY_W-1:0] wr_entry;

  // Capture-side next values. They are also used on the edge that enters
  // DUMP so the oldest pointer accounts for the entry written on that edge.
  always_comb begin
    capture  = (state_q == S_ARMED) || (state_q == S_POST);
    wr_en    = capture && i_valid;
    pc_hit   = i_trig_pc_en && i_valid && (i_pc == i_trig_pc);
    trig     = (state_q == S_ARMED) && (i_force_trig || pc_hit);
    wr_ptr_d = wr_en ? (wr_ptr_q + 1'b1) : wr_ptr_q;
    count_d  = (wr_en && (count_q != DEPTH_C)) ? (count_q + ONE_C) : count_q;
    // When full, count mod DEPTH is 0 and the oldest entry sits at wr_ptr.
    oldest_ptr = wr_ptr_d - count_d[ADDR_W-1:0];
    wr_entry   = {i_pc, i_instr, i_rd, i_reg_write_en, i_rd_data, i_cycle};
  end

  // Trace storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      post_left_q <= '0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_entry_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_arm) begin
            state_q     <= S_ARMED;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            post_left_q <= '0;
            triggered_q <= 1'b0;
          end
        end

        S_ARMED: begin
          wr_ptr_q <= wr_ptr_d;
          count_q  <= count_d;
          if (trig) begin
            triggered_q <= 1'b1;
            post_left_q <= POST_C;
            if (POST_CNT == 0) begin
              state_q  <= S_DUMP;
              rd_ptr_q <= oldest_ptr;
            end else begin
              state_q <= S_POST;
            end
          end
        end

        S_POST: begin
          wr_ptr_q <= wr_ptr_d;
          count_q  <= count_d;
          // Only real writes consume the post-trigger window.
          if (i_valid) begin
            post_left_q <= post_left_q - ONE_C;
            if (post_left_q == ONE_C) begin
              state_q  <= S_DUMP;
              rd_ptr_q <= oldest_ptr;
            end
          end
        end

        S_DUMP: begin
          // count_q doubles as the number of beats not yet transferred,
          // including the one currently offered.
          if (!rd_valid_q) begin
            if (count_q == '0) begin
              state_q     <= S_IDLE;
              triggered_q <= 1'b0;
            end else begin
              rd_entry_q <= mem[rd_ptr_q];
              rd_ptr_q   <= rd_ptr_q + 1'b1;
              rd_valid_q <= 1'b1;
              rd_last_q  <= (count_q == ONE_C);
            end
          end else if (i_rd_ready) begin
            count_q <= count_q - ONE_C;
            if (count_q == ONE_C) begin
              rd_valid_q  <= 1'b0;
              rd_last_q   <= 1'b0;
              state_q     <= S_IDLE;
              triggered_q <= 1'b0;
            end else begin
              rd_entry_q <= mem[rd_ptr_q];
              rd_ptr_q   <= rd_ptr_q + 1'b1;
              rd_last_q  <= (count_q == TWO_C);
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_state     = state_q;
  assign o_count     = count_q;
  assign o_triggered = triggered_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_last   = rd_last_q;
  assign o_rd_pc     = rd_entry_q[133:102];
  assign o_rd_instr  = rd_entry_q[101:70];
  assign o_rd_rd     = rd_entry_q[69:65];
  assign o_rd_we     = rd_entry_q[64];
  assign o_rd_data   = rd_entry_q[63:32];
  assign o_rd_cycle  = rd_entry_q[31:0];

endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
Synthesizable retirement-trace capture buffer fed by the writeback pipeline register, i.e. the same retired-instruction bundle the simulation debug printer consumes. Records retired instructions into a circular buffer, supports a PC-match or forced trigger with a fixed post-trigger window, then freezes. Dumps the captured window oldest-first over a valid/ready stream for on-chip debug readout.

Parameters:
DEPTH, 16, entries in circular buffer; power of 2, >= 4
ADDR_W, 4, log2(DEPTH)
POST_CNT, 8, entries recorded after the trigger entry; must be < DEPTH

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  synchronous active-low reset
i_arm  in  1  pulse: start capture (honoured only in IDLE)
i_trig_pc_en  in  1  enable PC-match trigger
i_trig_pc  in  32  trigger PC
i_force_trig  in  1  unconditional trigger
i_valid  in  1  writeback stage holds a retiring instruction this cycle
i_pc  in  32  retiring PC
i_instr  in  32  retiring instruction word
i_rd  in  5  destination register
i_reg_write_en  in  1  register write enable
i_rd_data  in  32  writeback data
i_cycle  in  32  cycle counter value
o_state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DUMP
o_count  out  ADDR_W+1  valid entries held, saturates at DEPTH
o_triggered  out  1  trigger seen, held until leaving DUMP
o_rd_valid  out  1  readout beat valid
i_rd_ready  in  1  readout consumer ready
o_rd_last  out  1  final beat of dump
o_rd_pc / o_rd_instr / o_rd_data / o_rd_cycle  out  32 each  readout entry fields
o_rd_rd  out  5  readout rd
o_rd_we  out  1  readout reg_write_en

Behaviour:
- Reset (i_rst_n low at rising edge): state IDLE, wr_ptr=0, rd_ptr=0, count=0, post_left=0; all outputs 0. Buffer memory contents are not reset. Reset in any state, including mid-dump, takes effect at that edge.
- Entry = {pc, instr, rd, reg_write_en, rd_data, cycle}, written at mem[wr_ptr] on the edge where capture is active and i_valid=1; wr_ptr increments mod DEPTH; count = min(count+1, DEPTH).
- IDLE: no capture; triggers ignored. i_arm -> ARMED; wr_ptr, count, o_triggered cleared.
- ARMED: capture every valid. Trigger condition = i_force_trig OR (i_trig_pc_en AND i_valid AND i_pc==i_trig_pc). On trigger: o_triggered=1; the same-cycle valid entry is written as the trigger entry; post_left=POST_CNT; next state POST, or DUMP if POST_CNT==0. i_force_trig with i_valid=0 triggers without writing.
- POST: capture continues; post_left decrements only on valid writes; the write that brings post_left to 0 moves to DUMP. Further triggers ignored.
- DUMP: capture disabled. On entry rd_ptr = (wr_ptr - count) mod DEPTH (oldest), remaining=count. Output fields are registered: first beat has o_rd_valid=1 on the cycle after entering DUMP. Beat transfers when o_rd_valid AND i_rd_ready; the next entry is loaded on the same edge (no bubble). While o_rd_valid=1 and i_rd_ready=0, all o_rd_* hold stable. o_rd_last=1 with the beat where remaining==1. Edge after last transfer: o_rd_valid=0, o_triggered=0, state IDLE. count==0 in DUMP: go straight to IDLE, no beats.
- i_arm ignored outside IDLE. o_count reflects entries held; it decrements per transferred beat in DUMP.
- PC compare is full 32-bit equality; all pointer arithmetic is mod DEPTH.

Test Plan:
- DEPTH=16, POST_CNT=8: arm, stream 30 back-to-back valids PC=4k (k=0..29), i_trig_pc_en=1, i_trig_pc=0x50 -> POST from k=20, DUMP after k=28 write, count=16; 16 beats PC 0x34..0x70 in order, o_rd_last only on 0x70, k=29 not captured.
- Arm, 3 valids (PC 0x100,0x104,0x108), then valid PC 0x10C with i_force_trig, then 8 more valids -> 12 beats 0x100..0x12C, cycle fields monotonic.
- Repeat scenario 1 with i_rd_ready pseudo-random 50% -> exactly 16 beats, no loss or duplication, o_rd_* stable while valid and not ready.
- In POST insert i_valid=0 gaps of 1-3 cycles -> post_left decrements only on valid; still exactly 8 post-trigger entries.
- Assert i_rst_n=0 during beat 5 of a dump -> next edge o_rd_valid=0, o_state=0, o_count=0, o_triggered=0; subsequent arm restarts from count 0.
- In IDLE drive valids with matching PC and i_force_trig -> no state change, o_count stays 0; POST_CNT=0 build: trigger at PC 0x8 -> DUMP immediately, last beat PC 0x8.
